pc_seq: RTL

//   Next-address sequencer for the processor program counter. Decodes

---
 rtl/pc_seq_if.sv | 47 ++++
 rtl/pc_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_seq_if.sv
// Decode-side bundle for the pc next-address sequencer.
//   master : instruction decode / pc side (drives request, consumes pc load pair)
//   slave  : pc_seq
// Signals
//   en      advance qualifier; 0 = stall (pc holds its address)
//   op      request code: 0 NOP, 1 JMP, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 HALT, 7 NOP
//   zero    condition flag for JZ/JNZ
//   target  jump/call destination
//   pc_addr current pc address
//   load    pc load strobe (combinational)
//   data    pc load value; pc ends up at data+1
//   flush   squash the instruction fetched this cycle
//   halted  sequencer is in HALT
//   sp      return-stack occupancy 0..DEPTH
//   ovf     sticky: CALL with stack full
//   udf     sticky: RET with stack empty
//   state   debug view of the FSM state (0 RUN, 1 FLUSH, 2 HALT)
// Handshake: there is no valid/ready pair. A request on op is consumed on a
// rising edge only when en=1; with en=0 nothing is consumed and the pc is held.
interface pc_seq_if #(
    parameter int NBITS = 8,
    parameter int SPW   = 2
);
    logic             en;
    logic [2:0]       op;
    logic             zero;
    logic [NBITS-1:0] target;
    logic [NBITS-1:0] pc_addr;
    logic             load;
    logic [NBITS-1:0] data;
    logic             flush;
    logic             halted;
    logic [SPW:0]     sp;
    logic             ovf;
    logic             udf;
    logic [1:0]       state;

    modport master (
        output en, op, zero, target, pc_addr,
        input  load, data, flush, halted, sp, ovf, udf, state
    );

    modport slave (
        input  en, op, zero, target, pc_addr,
        output load, data, flush, halted, sp, ovf, udf, state
    );
endinterface

// File: rtl/pc_seq.sv
// Next-address sequencer for the processor program counter.
// Decodes jump/call/return/halt/stall requests into the pc load/data pair,
// keeps a hardware return-address stack and flags the fetched slot to squash
// after every taken redirect.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  pc_seq_if.slave: en/op/zero/target/pc_addr in; load/data (combinational),
//        flush/halted/sp/ovf/udf/state (registered) out
module pc_seq #(
    parameter int NBITS = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_JNZ  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    localparam logic [NBITS-1:0] ADDR_ONE = 1;
    localparam logic [SPW-1:0]   IDX_ONE  = 1;
    localparam logic [SPW:0]     SP_ONE   = 1;
    localparam logic [SPW:0]     SP_EMPTY = 0;
    localparam logic [SPW:0]     SP_FULL  = (SPW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [SPW:0]     sp_q;
    logic             flush_q, halted_q, ovf_q, udf_q;
    logic [NBITS-1:0] stack [DEPTH];

    logic             load_c;
    logic [NBITS-1:0] data_c;
    logic             push, pop, set_ovf, set_udf;
    logic [SPW-1:0]   top_idx;
    logic [NBITS-1:0] top;
    logic [NBITS-1:0] hold_data;

    // pc adds 1 after a load, so every load value is the wanted address minus one.
    assign hold_data = bus.pc_addr - ADDR_ONE;
    assign top_idx   = sp_q[SPW-1:0] - IDX_ONE;
    assign top       = stack[top_idx];

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        data_c  = hold_data;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.en) begin
                    load_c = 1'b1;
                end else begin
                    case (bus.op)
                        OP_JMP: begin
                            load_c  = 1'b1;
                            data_c  = bus.target - ADDR_ONE;
                            state_d = FLUSH;
                        end
                        OP_JZ, OP_JNZ: begin
                            // op[0] selects JNZ: taken when zero differs from op[0]
                            if (bus.zero != bus.op[0]) begin
                                load_c  = 1'b1;
                                data_c  = bus.target - ADDR_ONE;
                                state_d = FLUSH;
                            end
                        end
                        OP_CALL: begin
                            // A full stack loses the return address but the jump still happens.
                            load_c  = 1'b1;
                            data_c  = bus.target - ADDR_ONE;
                            state_d = FLUSH;
                            if (sp_q == SP_FULL) set_ovf = 1'b1;
                            else                 push    = 1'b1;
                        end
                        OP_RET: begin
                            // An empty stack has nowhere to return to: fall through.
                            if (sp_q == SP_EMPTY) begin
                                set_udf = 1'b1;
                            end else begin
                                pop     = 1'b1;
                                load_c  = 1'b1;
                                data_c  = top - ADDR_ONE;
                                state_d = FLUSH;
                            end
                        end
                        OP_HALT: begin
                            load_c  = 1'b1;
                            state_d = HALT;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            FLUSH: begin
                if (bus.en) state_d = RUN;
                else        load_c  = 1'b1;
            end
            HALT: begin
                load_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            sp_q     <= SP_EMPTY;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= (state_d == FLUSH);
            halted_q <= (state_d == HALT);
            if (push)     sp_q  <= sp_q + SP_ONE;
            else if (pop) sp_q  <= sp_q - SP_ONE;
            if (set_ovf)  ovf_q <= 1'b1;
            if (set_udf)  udf_q <= 1'b1;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (push) stack[sp_q[SPW-1:0]] <= bus.pc_addr;
    end

    assign bus.load   = load_c;
    assign bus.data   = data_c;
    assign bus.flush  = flush_q;
    assign bus.halted = halted_q;
    assign bus.sp     = sp_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;
    assign bus.state  = state_q;

endmodule
